// File: rtl/avalon_mm_sdram_arb.sv
// ============================================================================
// Module   : avalon_mm_sdram_arb
// Purpose  : Round-robin, burst-aware two-port Avalon-MM arbiter in front of
//            an SDRAM controller, with read-tag FIFO for read data routing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module avalon_mm_sdram_arb #(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 64,
    parameter int BURST_COUNT_WIDTH = 8,
    parameter int BYTE_ENABLE_WIDTH = DATA_WIDTH / 8,
    parameter int RD_TAG_DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        m0_address,
    input  logic [BURST_COUNT_WIDTH-1:0] m0_burst_count,
    input  logic [DATA_WIDTH-1:0]        m0_write_data,
    input  logic [BYTE_ENABLE_WIDTH-1:0] m0_byte_enable,
    input  logic                         m0_write,
    input  logic                         m0_read,
    output logic                         m0_wait_request,
    output logic [DATA_WIDTH-1:0]        m0_read_data,
    output logic                         m0_readdata_val,
    input  logic [ADDR_WIDTH-1:0]        m1_address,
    input  logic [BURST_COUNT_WIDTH-1:0] m1_burst_count,
    input  logic [DATA_WIDTH-1:0]        m1_write_data,
    input  logic [BYTE_ENABLE_WIDTH-1:0] m1_byte_enable,
    input  logic                         m1_write,
    input  logic                         m1_read,
    output logic                         m1_wait_request,
    output logic [DATA_WIDTH-1:0]        m1_read_data,
    output logic                         m1_readdata_val,
    output logic [ADDR_WIDTH-1:0]        s_address,
    output logic [BURST_COUNT_WIDTH-1:0] s_burst_count,
    output logic [DATA_WIDTH-1:0]        s_write_data,
    output logic [BYTE_ENABLE_WIDTH-1:0] s_byte_enable,
    output logic                         s_write,
    output logic                         s_read,
    input  logic                         s_wait_request,
    input  logic [DATA_WIDTH-1:0]        s_read_data,
    input  logic                         s_readdata_val
);

    localparam int                 c_ptr_w = $clog2(RD_TAG_DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(RD_TAG_DEPTH);
    localparam int                 c_bcw   = BURST_COUNT_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WR_BURST = 1'b1
    } state_t;

    state_t             r_state_q,      w_state_d;
    logic               r_last_grant_q, w_last_grant_d;
    logic               r_owner_q,      w_owner_d;
    logic [c_bcw-1:0]   r_remaining_q,  w_remaining_d;
    logic [c_bcw-1:0]   r_beat_cnt_q,   w_beat_cnt_d;
    logic [c_ptr_w-1:0] r_wr_ptr_q,     w_wr_ptr_d;
    logic [c_ptr_w-1:0] r_rd_ptr_q,     w_rd_ptr_d;
    logic [c_ptr_w:0]   r_count_q,      w_count_d;

    logic               r_tag_port_q [RD_TAG_DEPTH];
    logic [c_bcw-1:0]   r_tag_len_q  [RD_TAG_DEPTH];

    logic                  w_fifo_full, w_fifo_empty;
    logic                  w_elig0, w_elig1;
    logic                  w_gnt_vld, w_gnt_port;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [c_bcw-1:0]      w_sel_bc;
    logic                  w_sel_write, w_sel_read;
    logic                  w_accept, w_push, w_pop, w_rd_beat;
    logic                  w_head_port;
    logic [c_bcw-1:0]      w_head_len, w_beat_next;

    assign w_fifo_full  = (r_count_q == c_depth);
    assign w_fifo_empty = (r_count_q == '0);

    // Reads are held off whenever the tag FIFO is full, even if it pops this cycle.
    assign w_elig0 = m0_write | (m0_read & ~w_fifo_full);
    assign w_elig1 = m1_write | (m1_read & ~w_fifo_full);

    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_port = 1'b0;
        if (rst_n) begin
            if (r_state_q == ST_WR_BURST) begin
                w_gnt_vld  = 1'b1;
                w_gnt_port = r_owner_q;
            end else if (w_elig0 && w_elig1) begin
                w_gnt_vld  = 1'b1;
                w_gnt_port = ~r_last_grant_q;
            end else if (w_elig0 || w_elig1) begin
                w_gnt_vld  = 1'b1;
                w_gnt_port = w_elig1;
            end
        end
    end

    assign w_sel_addr  = w_gnt_port ? m1_address     : m0_address;
    assign w_sel_bc    = w_gnt_port ? m1_burst_count : m0_burst_count;
    assign w_sel_write = w_gnt_port ? m1_write       : m0_write;
    assign w_sel_read  = w_gnt_port ? m1_read        : m0_read;

    assign s_address     = w_sel_addr;
    assign s_burst_count = w_sel_bc;
    assign s_write_data  = w_gnt_port ? m1_write_data  : m0_write_data;
    assign s_byte_enable = w_gnt_port ? m1_byte_enable : m0_byte_enable;
    assign s_write       = w_gnt_vld & w_sel_write;
    assign s_read        = w_gnt_vld & w_sel_read & ~w_sel_write
                         & (r_state_q == ST_IDLE) & ~w_fifo_full;

    assign m0_wait_request = ~(w_gnt_vld & ~w_gnt_port) | s_wait_request;
    assign m1_wait_request = ~(w_gnt_vld &  w_gnt_port) | s_wait_request;

    assign w_accept = (s_read | s_write) & ~s_wait_request;
    assign w_push   = w_accept & s_read;

    assign w_head_port = r_tag_port_q[r_rd_ptr_q];
    assign w_head_len  = r_tag_len_q[r_rd_ptr_q];
    assign w_beat_next = r_beat_cnt_q + c_bcw'(1);
    // Returns with no outstanding tag are dropped.
    assign w_rd_beat   = rst_n & s_readdata_val & ~w_fifo_empty;
    assign w_pop       = w_rd_beat & (w_beat_next == w_head_len);

    assign m0_read_data    = s_read_data;
    assign m1_read_data    = s_read_data;
    assign m0_readdata_val = w_rd_beat & ~w_head_port;
    assign m1_readdata_val = w_rd_beat &  w_head_port;

    always_comb begin
        w_state_d      = r_state_q;
        w_last_grant_d = r_last_grant_q;
        w_owner_d      = r_owner_q;
        w_remaining_d  = r_remaining_q;
        w_beat_cnt_d   = r_beat_cnt_q;
        w_wr_ptr_d     = r_wr_ptr_q;
        w_rd_ptr_d     = r_rd_ptr_q;
        w_count_d      = r_count_q;

        if (w_accept) begin
            w_last_grant_d = w_gnt_port;
        end

        case (r_state_q)
            ST_IDLE: begin
                if (w_accept && s_write && (w_sel_bc > c_bcw'(1))) begin
                    w_state_d     = ST_WR_BURST;
                    w_owner_d     = w_gnt_port;
                    w_remaining_d = w_sel_bc - c_bcw'(1);
                end
            end
            ST_WR_BURST: begin
                if (w_accept && s_write) begin
                    w_remaining_d = r_remaining_q - c_bcw'(1);
                    if (r_remaining_q == c_bcw'(1)) begin
                        w_state_d = ST_IDLE;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        if (w_rd_beat) begin
            w_beat_cnt_d = w_pop ? '0 : w_beat_next;
        end
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_ptr_w'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_ptr_w'(1);
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + (c_ptr_w + 1)'(1);
            2'b01:   w_count_d = r_count_q - (c_ptr_w + 1)'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q      <= ST_IDLE;
            r_last_grant_q <= 1'b1;
            r_owner_q      <= 1'b0;
            r_remaining_q  <= '0;
            r_beat_cnt_q   <= '0;
            r_wr_ptr_q     <= '0;
            r_rd_ptr_q     <= '0;
            r_count_q      <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_last_grant_q <= w_last_grant_d;
            r_owner_q      <= w_owner_d;
            r_remaining_q  <= w_remaining_d;
            r_beat_cnt_q   <= w_beat_cnt_d;
            r_wr_ptr_q     <= w_wr_ptr_d;
            r_rd_ptr_q     <= w_rd_ptr_d;
            r_count_q      <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_port_q[r_wr_ptr_q] <= w_gnt_port;
            r_tag_len_q[r_wr_ptr_q]  <= w_sel_bc;
        end
    end

`ifndef SYNTHESIS
    localparam int c_cmd_w = ADDR_WIDTH + c_bcw + 2;

    logic               r_chk_stall0_q, r_chk_stall1_q;
    logic [c_cmd_w-1:0] r_chk_cmd0_q,   r_chk_cmd1_q;
    logic [c_cmd_w-1:0] w_chk_cmd0,     w_chk_cmd1;

    assign w_chk_cmd0 = {m0_read, m0_write, m0_address, m0_burst_count};
    assign w_chk_cmd1 = {m1_read, m1_write, m1_address, m1_burst_count};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chk_stall0_q <= 1'b0;
            r_chk_stall1_q <= 1'b0;
        end else begin
            r_chk_stall0_q <= m0_wait_request & (m0_read | m0_write);
            r_chk_stall1_q <= m1_wait_request & (m1_read | m1_write);
        end
        r_chk_cmd0_q <= w_chk_cmd0;
        r_chk_cmd1_q <= w_chk_cmd1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_accept && (s_burst_count == '0)));
            assert (!(r_chk_stall0_q && (w_chk_cmd0 != r_chk_cmd0_q)));
            assert (!(r_chk_stall1_q && (w_chk_cmd1 != r_chk_cmd1_q)));
            assert (!(s_readdata_val && w_fifo_empty));
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_avalon_mm_sdram_arb.sv
// ============================================================================
// Module   : tb_avalon_mm_sdram_arb
// Purpose  : Directed self-checking bench for avalon_mm_sdram_arb.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_avalon_mm_sdram_arb;

    logic        clk;
    logic        rst_n;
    logic [31:0] m0_address,     m1_address;
    logic [7:0]  m0_burst_count, m1_burst_count;
    logic [63:0] m0_write_data,  m1_write_data;
    logic [7:0]  m0_byte_enable, m1_byte_enable;
    logic        m0_write, m0_read, m1_write, m1_read;
    logic        m0_wait_request, m1_wait_request;
    logic [63:0] m0_read_data, m1_read_data;
    logic        m0_readdata_val, m1_readdata_val;
    logic [31:0] s_address;
    logic [7:0]  s_burst_count;
    logic [63:0] s_write_data;
    logic [7:0]  s_byte_enable;
    logic        s_write, s_read;
    logic        s_wait_request;
    logic [63:0] s_read_data;
    logic        s_readdata_val;

    int vectors     = 0;
    int miscompares = 0;

    avalon_mm_sdram_arb dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m0_address      (m0_address),
        .m0_burst_count  (m0_burst_count),
        .m0_write_data   (m0_write_data),
        .m0_byte_enable  (m0_byte_enable),
        .m0_write        (m0_write),
        .m0_read         (m0_read),
        .m0_wait_request (m0_wait_request),
        .m0_read_data    (m0_read_data),
        .m0_readdata_val (m0_readdata_val),
        .m1_address      (m1_address),
        .m1_burst_count  (m1_burst_count),
        .m1_write_data   (m1_write_data),
        .m1_byte_enable  (m1_byte_enable),
        .m1_write        (m1_write),
        .m1_read         (m1_read),
        .m1_wait_request (m1_wait_request),
        .m1_read_data    (m1_read_data),
        .m1_readdata_val (m1_readdata_val),
        .s_address       (s_address),
        .s_burst_count   (s_burst_count),
        .s_write_data    (s_write_data),
        .s_byte_enable   (s_byte_enable),
        .s_write         (s_write),
        .s_read          (s_read),
        .s_wait_request  (s_wait_request),
        .s_read_data     (s_read_data),
        .s_readdata_val  (s_readdata_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int n1;
        int beat;
        logic [6:0] rd_pat;

        rst_n = 1'b0;
        m0_address = '0; m1_address = '0;
        m0_burst_count = 8'd1; m1_burst_count = 8'd1;
        m0_write_data = '0; m1_write_data = '0;
        m0_byte_enable = 8'hFF; m1_byte_enable = 8'h0F;
        m0_write = 1'b0; m0_read = 1'b0; m1_write = 1'b0; m1_read = 1'b0;
        s_wait_request = 1'b0; s_read_data = '0; s_readdata_val = 1'b0;

        // Reset state
        tick(); tick(); #2;
        chk1("rst_m0_wait", m0_wait_request, 1'b1);
        chk1("rst_m1_wait", m1_wait_request, 1'b1);
        chk1("rst_s_read",  s_read,          1'b0);
        chk1("rst_s_write", s_write,         1'b0);
        chk1("rst_m0_rdv",  m0_readdata_val, 1'b0);
        chk1("rst_m1_rdv",  m1_readdata_val, 1'b0);

        // Alternating single-beat writes, port 0 first
        tick();
        rst_n = 1'b1;
        m0_address = 32'h100; m1_address = 32'h200;
        m0_write = 1'b1; m1_write = 1'b1;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            m0_write = (k <= 6);
            #2;
            chk1("alt_s_write", s_write, 1'b1);
            chk64("alt_s_addr", 64'(s_address), (k % 2 == 1) ? 64'h200 : 64'h100);
            chk1("alt_m0_wait", m0_wait_request, (k % 2 == 1));
            chk1("alt_m1_wait", m1_wait_request, (k % 2 == 0));
            if (s_write && !s_wait_request) begin
                if (s_address == 32'h100) n0++;
                else n1++;
            end
        end
        chk64("alt_n0", 64'(n0), 64'd4);
        chk64("alt_n1", 64'(n1), 64'd4);
        tick();
        m0_write = 1'b0; m1_write = 1'b0;

        // Port 0 write burst of 4 with a stalled beat; port 1 locked out
        m0_write = 1'b1; m0_burst_count = 8'd4; m0_address = 32'h1000;
        m0_write_data = 64'hA0;
        #2;
        chk64("wb_bc",      64'(s_burst_count), 64'd4);
        chk1("wb_c0_m0_wait", m0_wait_request, 1'b0);
        tick();
        m0_write_data = 64'hA1;
        m1_write = 1'b1; m1_burst_count = 8'd1; m1_address = 32'h2000;
        s_wait_request = 1'b1;
        #2;
        chk1("wb_c1_m0_wait", m0_wait_request, 1'b1);
        chk1("wb_c1_m1_wait", m1_wait_request, 1'b1);
        chk1("wb_c1_s_write", s_write, 1'b1);
        chk64("wb_c1_data", s_write_data, 64'hA1);
        tick();
        s_wait_request = 1'b0;
        #2;
        chk1("wb_c2_m0_wait", m0_wait_request, 1'b0);
        chk1("wb_c2_m1_wait", m1_wait_request, 1'b1);
        tick();
        m0_write_data = 64'hA2;
        #2;
        chk1("wb_c3_m1_wait", m1_wait_request, 1'b1);
        tick();
        m0_write_data = 64'hA3;
        #2;
        chk1("wb_c4_m0_wait", m0_wait_request, 1'b0);
        chk1("wb_c4_m1_wait", m1_wait_request, 1'b1);
        tick();
        m0_write = 1'b0;
        #2;
        chk1("wb_c5_m1_wait", m1_wait_request, 1'b0);
        chk64("wb_c5_addr", 64'(s_address), 64'h2000);
        chk64("wb_c5_bc",   64'(s_burst_count), 64'd1);
        tick();
        m1_write = 1'b0;

        // Read routing: port 0 burst 3, port 1 burst 2, returns with gaps
        m0_read = 1'b1; m0_burst_count = 8'd3; m0_address = 32'h3000;
        #2;
        chk1("rd_m0_s_read", s_read, 1'b1);
        chk1("rd_m0_wait",   m0_wait_request, 1'b0);
        tick();
        m0_read = 1'b0;
        m1_read = 1'b1; m1_burst_count = 8'd2; m1_address = 32'h4000;
        #2;
        chk64("rd_m1_addr", 64'(s_address), 64'h4000);
        chk1("rd_m1_wait",  m1_wait_request, 1'b0);
        tick();
        m1_read = 1'b0;
        #2;
        chk64("rd_count2", 64'(dut.r_count_q), 64'd2);
        rd_pat = 7'b1101101;
        beat = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            s_readdata_val = rd_pat[i];
            s_read_data = 64'hD0 + 64'(i);
            #2;
            chk1("rd_m0_rdv", m0_readdata_val, rd_pat[i] && (beat < 3));
            chk1("rd_m1_rdv", m1_readdata_val, rd_pat[i] && (beat >= 3));
            chk64("rd_m1_data", m1_read_data, 64'hD0 + 64'(i));
            if (rd_pat[i]) beat++;
        end
        tick();
        s_readdata_val = 1'b0;
        #2;
        chk64("rd_empty", 64'(dut.r_count_q), 64'd0);

        // Fill the tag FIFO with 8 reads; 9th read blocked, writes proceed
        m0_read = 1'b1; m0_burst_count = 8'd1; m0_address = 32'h5000;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            #2;
            chk1("full_fill_m0_wait", m0_wait_request, 1'b0);
        end
        tick();
        m1_write = 1'b1; m1_burst_count = 8'd1; m1_address = 32'h6000;
        #2;
        chk1("full_m0_wait",  m0_wait_request, 1'b1);
        chk1("full_s_read",   s_read,          1'b0);
        chk1("full_m1_wait",  m1_wait_request, 1'b0);
        chk1("full_s_write",  s_write,         1'b1);
        tick();
        m1_write = 1'b0;
        s_readdata_val = 1'b1; s_read_data = 64'hE0;
        #2;
        chk1("full_pop_m0_rdv",  m0_readdata_val, 1'b1);
        chk1("full_pop_m0_wait", m0_wait_request, 1'b1);
        tick();
        s_readdata_val = 1'b0;
        #2;
        chk1("full_after_m0_wait", m0_wait_request, 1'b0);
        chk1("full_after_s_read",  s_read,          1'b1);
        tick();
        m0_read = 1'b0;
        #2;
        chk64("full_count8", 64'(dut.r_count_q), 64'd8);
        for (int i = 0; i < 8; i++) begin
            s_readdata_val = 1'b1;
            s_read_data = 64'(i);
            #1;
            chk1("drain_m0_rdv", m0_readdata_val, 1'b1);
            tick();
        end
        s_readdata_val = 1'b0;
        #2;
        chk64("drain_empty", 64'(dut.r_count_q), 64'd0);

        // Pop and push in the same cycle
        m1_read = 1'b1; m1_burst_count = 8'd2; m1_address = 32'h7000;
        #2;
        chk1("pp_m1_wait", m1_wait_request, 1'b0);
        tick();
        m1_read = 1'b0;
        s_readdata_val = 1'b1;
        #2;
        chk1("pp_b1_m1_rdv", m1_readdata_val, 1'b1);
        tick();
        m0_read = 1'b1; m0_burst_count = 8'd1; m0_address = 32'h8000;
        #2;
        chk1("pp_b2_m1_rdv",  m1_readdata_val, 1'b1);
        chk1("pp_b2_m0_rdv",  m0_readdata_val, 1'b0);
        chk1("pp_b2_m0_wait", m0_wait_request, 1'b0);
        tick();
        m0_read = 1'b0;
        s_readdata_val = 1'b0;
        #2;
        chk64("pp_count", 64'(dut.r_count_q), 64'd1);
        s_readdata_val = 1'b1;
        #1;
        chk1("pp_m0_rdv", m0_readdata_val, 1'b1);
        chk1("pp_m1_rdv", m1_readdata_val, 1'b0);
        tick();
        s_readdata_val = 1'b0;
        #2;
        chk64("pp_empty", 64'(dut.r_count_q), 64'd0);

        // Reset mid write burst with 3 tags outstanding
        m1_read = 1'b1; m1_burst_count = 8'd1; m1_address = 32'h9000;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            #2;
            chk1("mr_rd_m1_wait", m1_wait_request, 1'b0);
        end
        tick();
        m1_read = 1'b0;
        m0_write = 1'b1; m0_burst_count = 8'd4; m0_address = 32'hA000;
        #2;
        chk64("mr_count3", 64'(dut.r_count_q), 64'd3);
        chk1("mr_b1_m0_wait", m0_wait_request, 1'b0);
        tick();
        #2;
        chk1("mr_b2_m0_wait", m0_wait_request, 1'b0);
        tick();
        rst_n = 1'b0;
        m1_write = 1'b1; m1_burst_count = 8'd1; m1_address = 32'hB000;
        #2;
        chk1("mr_in_m0_wait", m0_wait_request, 1'b1);
        chk1("mr_in_m1_wait", m1_wait_request, 1'b1);
        chk1("mr_in_s_write", s_write,         1'b0);
        tick();
        #2;
        chk64("mr_count0",     64'(dut.r_count_q), 64'd0);
        chk1("mr_next_m0_wait", m0_wait_request, 1'b1);
        chk1("mr_next_m1_wait", m1_wait_request, 1'b1);
        chk1("mr_next_s_write", s_write,         1'b0);
        tick();
        rst_n = 1'b1;
        m0_burst_count = 8'd1;
        #2;
        chk1("mr_rel_m0_wait", m0_wait_request, 1'b0);
        chk1("mr_rel_m1_wait", m1_wait_request, 1'b1);
        chk64("mr_rel_addr",   64'(s_address), 64'hA000);
        tick();
        m0_write = 1'b0;
        #2;
        chk1("mr_m1_wait", m1_wait_request, 1'b0);
        tick();
        m1_write = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/avalon_mm_sdram_arb.md
Name: avalon_mm_sdram_arb

Overview:
- Two-port arbiter that shares one Avalon-MM SDRAM master port between two requesters, e.g. the packet DMA and the HPS bridge.
- Arbitration is round-robin and burst-aware. A write burst locks the grant until its final beat is accepted.
- Read bursts are tagged in a small FIFO so that returning read data is routed to the port that issued the read.
- Sits between the requesters and the SDRAM controller slave port.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 64, data width.
- BURST_COUNT_WIDTH, 8, burst_count width.
- BYTE_ENABLE_WIDTH, DATA_WIDTH/8, byte enable width.
- RD_TAG_DEPTH, 8, maximum outstanding read bursts (power of 2).

Ports:
- clk  in  1  system clock, shared by all ports.
- rst_n  in  1  synchronous active-low reset.
- mN_address  in  ADDR_WIDTH  requester N (N=0,1) address.
- mN_burst_count  in  BURST_COUNT_WIDTH  requester N burst length; legal range 1..2^BCW-1.
- mN_write_data  in  DATA_WIDTH  requester N write data.
- mN_byte_enable  in  BYTE_ENABLE_WIDTH  requester N byte enables.
- mN_write  in  1  requester N write.
- mN_read  in  1  requester N read.
- mN_wait_request  out  1  requester N stall.
- mN_read_data  out  DATA_WIDTH  read data, broadcast to both requesters.
- mN_readdata_val  out  1  read data valid, asserted only toward the owning port.
- s_address, s_burst_count, s_write_data, s_byte_enable, s_write, s_read  out  matching widths  toward the SDRAM controller.
- s_wait_request  in  1  SDRAM controller stall.
- s_read_data  in  DATA_WIDTH  SDRAM controller read data.
- s_readdata_val  in  1  SDRAM controller read data valid.

Behaviour:
- Clock and reset: one clock `clk`; synchronous active-low reset `rst_n`.
- Reset values:
  - state=IDLE, tag FIFO empty, beat counters 0, last_grant=1 (so port 0 wins first).
  - m0/m1_wait_request=1, m0/m1_readdata_val=0, s_read=0, s_write=0.
- Request definition: req_N = mN_read | mN_write. A read from port N is eligible only if the tag FIFO is not full.
- States: IDLE, WR_BURST.
- IDLE:
  - Grant is combinational, so there is no bubble cycle.
  - If exactly one port has an eligible request, that port is granted.
  - If both have eligible requests, the port != last_grant is granted.
  - With no grant, s_read=s_write=0.
- Command mux: the granted port's command is driven onto the s_* signals, and mN_wait_request = s_wait_request for it. The non-granted port sees wait_request=1.
- A command is accepted when (s_read|s_write) & !s_wait_request. On acceptance, last_grant is set to the granted port.
- Accepted write with burst_count>1: go to WR_BURST, latch the owner, remaining = burst_count-1.
- Accepted write with burst_count=1: stay in IDLE.
- Accepted read: push {port, burst_count} into the tag FIFO and stay in IDLE.
- WR_BURST:
  - Grant is locked to the owner; the other port sees wait_request=1.
  - Each accepted write beat decrements remaining.
  - When the beat with remaining=1 is accepted, go to IDLE; the next cycle is re-arbitrated.
  - Beats stalled by s_wait_request do not count.
- Read return:
  - s_read_data goes to both m*_read_data combinationally.
  - On s_readdata_val, readdata_val is asserted (combinationally) to the FIFO-head port only.
  - The beat counter increments; when it equals the head burst_count, pop the head and clear the counter.
  - s_readdata_val with the FIFO empty is a protocol error: drop the beat and flag it via a simulation assertion.
- Simultaneous events:
  - Push and pop in the same cycle are both performed, and the count is unchanged.
  - When the FIFO is full, reads are blocked even if a pop occurs in the same cycle (conservative).
  - Writes are never blocked by FIFO state.
- Simulation assertions: burst_count=0 on an accepted command; a requester changing its command while stalled.
- Reset mid-operation: any burst in progress and all tags are discarded. The SDRAM controller must be reset in the same cycle.

Test Plan:
- Both ports issue 1-beat writes every cycle, s_wait_request=0 -> grants alternate 0,1,0,1 starting at port 0; 4 writes per port in 8 cycles.
- Port 0 writes burst_count=4 while port 1 requests from cycle 1, with s_wait_request=1 on beat 2 -> port 1 stalled until the 4th port-0 beat is accepted (5 cycles); port 1 granted next cycle.
- Port 0 reads burst 3, then port 1 reads burst 2; SDRAM returns 5 valid beats with gaps -> beats 1-3 show m0_readdata_val only, beats 4-5 m1_readdata_val only; FIFO empty afterwards.
- Issue 8 single-beat reads with no returns -> the 9th read keeps wait_request=1 while writes from the other port still proceed; after one return, the read is accepted the following cycle.
- Read return (pop) coincides with a new read acceptance (push) -> FIFO count unchanged, routing correct.
- Assert rst_n=0 mid write burst and with 3 tags outstanding -> next cycle: all wait_request=1, s_write=0, FIFO empty; after release, port 0 granted first.
